// File: rtl/regfile_read_arbiter_pkg.sv
// regfile_read_arbiter_pkg
//   Shared definitions for the Reg_File port-2 read arbiter:
//   - FSM state encodings (IDLE, WAIT, STEAL, RESP)
//   - default starvation limit used by the arbiter parameter
package regfile_read_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STEAL = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares Reg_File read port 2 between the ID stage (rt operand) and a
//   debug read channel. Debug reads take port-2 cycles the ID stage does
//   not need; after STARVE_LIMIT waiting cycles a one-cycle stall is
//   requested from the Hazard unit so the port can be stolen.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   id_rt_used         ID instruction reads rt this cycle
//   id_rt_addr         ID rt register address
//   hazard_stall       Hazard unit already holds ID this cycle
//   wb_reg_write       WB stage writes the register file this cycle
//   wb_addr, wb_data   WB destination and data (bypassed into captures)
//   rf_read_addr_2     Reg_File ReadRegister2
//   rf_read_data_2     Reg_File read_data2 (combinational)
//   dbg_req_valid/addr/ready   debug request handshake
//   dbg_rsp_valid/data         one-cycle response pulse and held data
//   stall_req          hold PC and IF_ID, flush ID_EX this cycle
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              hazard_stall,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_read_addr_2,
    input  logic [DATA_W-1:0] rf_read_data_2,
    input  logic              dbg_req_valid,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    output logic              dbg_req_ready,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              stall_req
);

    localparam int               CNT_W    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              port_free;
    logic              grant;

    // A write landing in WB during the grant cycle is not yet visible in
    // the register file, so forward it. Register 0 is hard-wired to zero.
    function automatic logic [DATA_W-1:0] select_capture(
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [ADDR_W-1:0] rd_addr,
        input logic [DATA_W-1:0] rd_data
    );
        if (wr_en && (wr_addr == rd_addr) && (rd_addr != '0)) begin
            return wr_data;
        end
        return rd_data;
    endfunction

    assign dbg_req_ready  = (state_q == ST_IDLE);
    assign accept         = dbg_req_valid && dbg_req_ready;
    // ID does not need port 2 when it has no rt operand or is being held.
    assign port_free      = !id_rt_used || hazard_stall;
    assign grant          = ((state_q == ST_WAIT) && port_free) || (state_q == ST_STEAL);

    assign rf_read_addr_2 = grant ? addr_q : id_rt_addr;
    // Gated by reset so a response or stall in flight drops in the reset cycle.
    assign stall_req      = (state_q == ST_STEAL) && !reset;
    assign dbg_rsp_valid  = (state_q == ST_RESP) && !reset;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (dbg_req_addr == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (port_free) begin
                    state_d = ST_RESP;
                end else if (starve_cnt_q == CNT_LAST) begin
                    state_d = ST_STEAL;
                end
            end
            ST_STEAL: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            dbg_rsp_data <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                addr_q       <= dbg_req_addr;
                starve_cnt_q <= '0;
            end else if ((state_q == ST_WAIT) && !port_free && (starve_cnt_q != CNT_LAST)) begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end

            // Register 0 never touches the port; its response is a constant zero.
            if (accept && (dbg_req_addr == '0)) begin
                dbg_rsp_data <= '0;
            end else if (grant) begin
                dbg_rsp_data <= select_capture(wb_reg_write, wb_addr, wb_data,
                                               addr_q, rf_read_data_2);
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

    localparam int L  = 8;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_rt_used;
    logic [AW-1:0] id_rt_addr;
    logic          hazard_stall;
    logic          wb_reg_write;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_read_addr_2;
    logic [DW-1:0] rf_read_data_2;
    logic          dbg_req_valid;
    logic [AW-1:0] dbg_req_addr;
    logic          dbg_req_ready;
    logic          dbg_rsp_valid;
    logic [DW-1:0] dbg_rsp_data;
    logic          stall_req;

    logic [DW-1:0] regs [32];
    assign rf_read_data_2 = regs[rf_read_addr_2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] last_data;

    // Per-cycle stimulus, indexed by cycle offset from the accept cycle (k=0).
    logic          s_used [16];
    logic          s_haz  [16];
    logic          s_wbw  [16];
    logic [AW-1:0] s_wba  [16];
    logic [DW-1:0] s_wbd  [16];
    logic [AW-1:0] s_rt   [16];

    regfile_read_arbiter #(
        .STARVE_LIMIT(L),
        .DATA_W      (DW),
        .ADDR_W      (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rt_used    (id_rt_used),
        .id_rt_addr    (id_rt_addr),
        .hazard_stall  (hazard_stall),
        .wb_reg_write  (wb_reg_write),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_2(rf_read_data_2),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_addr  (dbg_req_addr),
        .dbg_req_ready (dbg_req_ready),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .stall_req     (stall_req)
    );

    always #5 clock = ~clock;

    task automatic fill(input int pu, input int ph, input int pw, input logic [AW-1:0] a);
        for (int k = 0; k < 16; k++) begin
            s_used[k] = ($urandom_range(0, 99) < pu);
            s_haz[k]  = ($urandom_range(0, 99) < ph);
            s_wbw[k]  = ($urandom_range(0, 99) < pw);
            s_wba[k]  = ($urandom_range(0, 1) == 1) ? a : AW'($urandom);
            s_wbd[k]  = $urandom;
            s_rt[k]   = AW'($urandom);
        end
    endtask

    task automatic quiet_inputs();
        dbg_req_valid = 1'b0;
        dbg_req_addr  = '0;
        id_rt_used    = 1'b0;
        id_rt_addr    = '0;
        hazard_stall  = 1'b0;
        wb_reg_write  = 1'b0;
        wb_addr       = '0;
        wb_data       = '0;
    endtask

    // Runs one debug request starting in an IDLE cycle and checks every cycle
    // up to and including the response. Expected timing comes from the rules:
    // first free WAIT cycle in 1..L grants, otherwise a steal in cycle L+1;
    // the response follows the grant by one cycle (address 0 responds at 1).
    task automatic run_req(input logic [AW-1:0] a, input string name);
        int g;
        int steal;
        int rsp;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] exp_ra;
        g = -1;
        steal = -1;
        if (a != '0) begin
            for (int k = 1; k <= L; k++) begin
                if (g < 0 && (!s_used[k] || s_haz[k])) g = k;
            end
            if (g < 0) begin
                g = L + 1;
                steal = L + 1;
            end
            rsp = g + 1;
        end else begin
            rsp = 1;
        end
        exp_d = '0;
        for (int k = 0; k <= rsp; k++) begin
            dbg_req_valid = (k == 0);
            dbg_req_addr  = (k == 0) ? a : AW'($urandom);
            id_rt_used    = s_used[k];
            hazard_stall  = s_haz[k];
            id_rt_addr    = s_rt[k];
            wb_reg_write  = s_wbw[k];
            wb_addr       = s_wba[k];
            wb_data       = s_wbd[k];
            @(negedge clock);
            if (k == g) exp_d = (s_wbw[k] && s_wba[k] == a) ? s_wbd[k] : regs[a];
            n_checks++;
            if (dbg_req_ready !== (k == 0)) begin
                n_fail++;
                $display("FAIL %s ready k=%0d got %0b exp %0b", name, k, dbg_req_ready, (k == 0));
            end
            n_checks++;
            if (dbg_rsp_valid !== (k == rsp)) begin
                n_fail++;
                $display("FAIL %s rsp_valid k=%0d got %0b exp %0b", name, k, dbg_rsp_valid, (k == rsp));
            end
            n_checks++;
            if (stall_req !== (k == steal)) begin
                n_fail++;
                $display("FAIL %s stall_req k=%0d got %0b exp %0b", name, k, stall_req, (k == steal));
            end
            exp_ra = (k == g) ? a : s_rt[k];
            n_checks++;
            if (rf_read_addr_2 !== exp_ra) begin
                n_fail++;
                $display("FAIL %s rf_read_addr_2 k=%0d got %0d exp %0d", name, k, rf_read_addr_2, exp_ra);
            end
            if (k == 0) begin
                n_checks++;
                if (dbg_rsp_data !== last_data) begin
                    n_fail++;
                    $display("FAIL %s held_data got %h exp %h", name, dbg_rsp_data, last_data);
                end
            end
            if (k == rsp) begin
                n_checks++;
                if (dbg_rsp_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL %s rsp_data addr=%0d got %h exp %h", name, a, dbg_rsp_data, exp_d);
                end
            end
            @(posedge clock);
            if (wb_reg_write && wb_addr != '0) regs[wb_addr] = wb_data;
            #1;
        end
        last_data = exp_d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet_inputs();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        id_rt_addr = 5'd17;
        @(negedge clock);
        n_checks++;
        if (dbg_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready got %0b exp 1", dbg_req_ready);
        end
        n_checks++;
        if (dbg_rsp_valid !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset rsp_valid/stall got %0b/%0b exp 0/0", dbg_rsp_valid, stall_req);
        end
        n_checks++;
        if (dbg_rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset rsp_data got %h exp 0", dbg_rsp_data);
        end
        n_checks++;
        if (rf_read_addr_2 !== 5'd17) begin
            n_fail++;
            $display("FAIL reset rf_read_addr_2 got %0d exp 17", rf_read_addr_2);
        end
        @(posedge clock);
        #1;
        last_data = '0;
    endtask

    task automatic test_idle_port();
        regs[9] = 32'h0000_1234;
        fill(0, 0, 0, 9);
        run_req(5'd9, "idle_port");
    endtask

    task automatic test_starvation();
        regs[5] = 32'h5555_AAAA;
        fill(100, 0, 0, 5);
        run_req(5'd5, "starvation");
    endtask

    task automatic test_hazard_window();
        regs[3] = 32'h3333_0003;
        fill(100, 0, 0, 3);
        s_haz[3] = 1'b1;
        run_req(5'd3, "hazard_window");
    endtask

    task automatic test_wb_bypass();
        regs[5] = 32'h0BAD_0BAD;
        fill(0, 0, 0, 5);
        s_wbw[1] = 1'b1; s_wba[1] = 5'd5; s_wbd[1] = 32'hDEAD_BEEF;
        run_req(5'd5, "wb_bypass");
        fill(100, 0, 0, 6);
        s_wbw[L+1] = 1'b1; s_wba[L+1] = 5'd6; s_wbd[L+1] = 32'hCAFE_F00D;
        run_req(5'd6, "wb_bypass_steal");
        regs[12] = 32'h1212_1212;
        fill(0, 0, 0, 12);
        s_wbw[1] = 1'b1; s_wba[1] = 5'd4; s_wbd[1] = 32'hFFFF_0000;
        run_req(5'd12, "wb_other_addr");
    endtask

    task automatic test_zero_reg();
        fill(50, 10, 50, 0);
        run_req(5'd0, "zero_reg");
    endtask

    task automatic test_back_to_back();
        fill(0, 0, 0, 21);
        run_req(5'd21, "b2b_a");
        fill(100, 0, 0, 22);
        run_req(5'd22, "b2b_b");
        fill(60, 20, 40, 23);
        run_req(5'd23, "b2b_c");
    endtask

    task automatic test_reset_mid();
        fill(100, 0, 0, 7);
        for (int k = 0; k <= 3; k++) begin
            dbg_req_valid = (k == 0);
            dbg_req_addr  = 5'd7;
            id_rt_used    = 1'b1;
            hazard_stall  = 1'b0;
            wb_reg_write  = 1'b0;
            reset         = (k == 3);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        for (int k = 4; k < 16; k++) begin
            @(negedge clock);
            if (k == 4) begin
                n_checks++;
                if (dbg_req_ready !== 1'b1 || dbg_rsp_data !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid ready/data got %0b/%h exp 1/0", dbg_req_ready, dbg_rsp_data);
                end
            end
            n_checks++;
            if (dbg_rsp_valid !== 1'b0 || stall_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid dropped k=%0d rsp_valid/stall got %0b/%0b exp 0/0", k, dbg_rsp_valid, stall_req);
            end
            @(posedge clock);
            #1;
        end
        last_data = '0;
        regs[7] = 32'h7777_0007;
        fill(70, 10, 30, 7);
        run_req(5'd7, "after_reset_mid");
    endtask

    task automatic test_reset_in_steal();
        for (int k = 0; k <= L + 1; k++) begin
            dbg_req_valid = (k == 0);
            dbg_req_addr  = 5'd11;
            id_rt_used    = 1'b1;
            hazard_stall  = 1'b0;
            wb_reg_write  = 1'b0;
            reset         = (k == L + 1);
            @(negedge clock);
            if (k == L + 1) begin
                n_checks++;
                if (stall_req !== 1'b0 || dbg_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_steal stall/rsp got %0b/%0b exp 0/0", stall_req, dbg_rsp_valid);
                end
            end
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        id_rt_used = 1'b0;
        @(negedge clock);
        n_checks++;
        if (dbg_req_ready !== 1'b1 || dbg_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_steal after ready/rsp got %0b/%0b exp 1/0", dbg_req_ready, dbg_rsp_valid);
        end
        @(posedge clock);
        #1;
        last_data = '0;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
            if ($urandom_range(0, 3) == 0) fill(100, 0, 50, a);
            else fill(75, 12, 50, a);
            run_req(a, "random");
        end
    endtask

    initial begin
        regs[0] = '0;
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        last_data = '0;
        test_reset();
        test_idle_port();
        test_starvation();
        test_hazard_window();
        test_wb_bypass();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_reset_in_steal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
